fwd_hazard_tracker: RTL and testbench

//  Parametrised forwarding/hazard unit for the 64-bit pipeline. Tracks in-flight writers in its own

---
 rtl/fwd_hazard_tracker_pkg.sv | 21 ++
 rtl/fwd_hazard_tracker_if.sv | 39 +++
 rtl/fwd_operand_match.sv | 33 +++
 rtl/fwd_hazard_tracker.sv | 100 ++++++++++
 tb/tb_fwd_hazard_tracker.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_tracker_pkg.sv
// Shared types and constants for the forwarding/hazard tracker.
// Tracker slot tags use FWD_REG_W; instantiate the tracker with a matching REG_W.
package fwd_pkg;

  localparam int FWD_REG_W   = 5;
  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic [FWD_REG_W-1:0] rd;
    logic                 is_load;
  } fwd_slot_t;

  // LEGv8 opcodes as seen by the decoder that produces id_src_used/id_is_load
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;

endpackage

// File: rtl/fwd_hazard_tracker_if.sv
// ID-stage request / EX forward-select bus between the pipeline and the hazard tracker.
// FWD_HAZARD_STATS_EN adds the stall/forward statistics counters to the bus.
interface fwd_hazard_tracker_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 3,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
);

  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_regwrite;
  logic                     id_is_load;
  logic                     stall_id;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0]              stat_stalls;
  logic [31:0]              stat_fwds;
`endif

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
`ifdef FWD_HAZARD_STATS_EN
    input  stat_stalls, stat_fwds,
`endif
    input  stall_id, ex_fwd_sel
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_is_load,
`ifdef FWD_HAZARD_STATS_EN
    output stat_stalls, stat_fwds,
`endif
    output stall_id, ex_fwd_sel
  );

endinterface

// File: rtl/fwd_operand_match.sv
// Per-operand match against the in-flight writer slots: youngest match gives the
// forward select, and flags a load-use hazard when that load is not yet forwardable.
module fwd_operand_match
  import fwd_pkg::*;
#(
  parameter int REG_W    = FWD_REG_W,
  parameter int ZERO_REG = 31,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  fwd_slot_t [NUM_FWD-1:0] slots,
  input  logic [REG_W-1:0]        src,
  input  logic                    used,
  output logic [SEL_W-1:0]        sel,
  output logic                    load_hazard
);

  // Scan oldest to youngest so the youngest matching writer overwrites older ones
  always_comb begin
    sel         = SEL_W'(SEL_REGFILE);
    load_hazard = 1'b0;
    if (used && (src != REG_W'(ZERO_REG))) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (slots[i].valid && (slots[i].rd == src)) begin
          sel         = SEL_W'(i + 1);
          load_hazard = slots[i].is_load && ((i + 1) < LOAD_LAT);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding/hazard unit: tracks in-flight writers, registers forward selects into EX
// and raises stall_id on load-use. FWD_HAZARD_STATS_EN adds stat_stalls/stat_fwds.
module fwd_hazard_tracker
  import fwd_pkg::*;
#(
  parameter int REG_W    = FWD_REG_W,
  parameter int ZERO_REG = 31,
  parameter int NUM_SRC  = 3,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 hold,
  input logic                 flush,
  fwd_hazard_tracker_if.slave bus
);

  fwd_slot_t [NUM_FWD-1:0]  slots;
  fwd_slot_t                id_entry;
  logic [NUM_SRC-1:0]       hazard;
  logic [NUM_SRC*SEL_W-1:0] cand_sel;
  logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel_q;
  logic                     stall;
  logic                     bubble;
  logic                     advance;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_match
    fwd_operand_match #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG),
      .NUM_FWD  (NUM_FWD),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_match (
      .slots       (slots),
      .src         (bus.id_src[k*REG_W +: REG_W]),
      .used        (bus.id_src_used[k]),
      .sel         (cand_sel[k*SEL_W +: SEL_W]),
      .load_hazard (hazard[k])
    );
  end

  assign stall        = bus.id_valid && !flush && (|hazard);
  assign bubble       = stall || flush || !bus.id_valid;
  // Flush overrides hold: the killed instructions must leave the pipe regardless
  assign advance      = !hold || flush;
  assign bus.stall_id = stall;
  assign bus.ex_fwd_sel = ex_fwd_sel_q;

  always_comb begin
    id_entry.valid   = !bubble && bus.id_regwrite && (bus.id_rd != REG_W'(ZERO_REG));
    id_entry.rd      = bus.id_rd;
    id_entry.is_load = bus.id_is_load;
  end

  // Slot shift register and EX select register; on flush the old slot[0] dies too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slots        <= '0;
      ex_fwd_sel_q <= '0;
    end else if (advance) begin
      slots[0] <= id_entry;
      for (int i = 1; i < NUM_FWD; i++) begin
        slots[i] <= (i == 1 && flush) ? fwd_slot_t'('0) : slots[i-1];
      end
      ex_fwd_sel_q <= bubble ? '0 : cand_sel;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] fwd_cnt;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (cand_sel[k*SEL_W +: SEL_W] != '0) fwd_cnt = fwd_cnt + 32'd1;
    end
    fwd_sum = {1'b0, bus.stat_fwds} + {1'b0, fwd_cnt};
  end

  // Saturating counters; forwards count only when the selects are actually latched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.stat_stalls <= '0;
      bus.stat_fwds   <= '0;
    end else begin
      if (stall && !hold && (bus.stat_stalls != '1)) begin
        bus.stat_stalls <= bus.stat_stalls + 32'd1;
      end
      if (advance && !bubble) begin
        bus.stat_fwds <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed self-checking bench for fwd_hazard_tracker with default parameters.
module tb_fwd_hazard_tracker;

  logic clk = 1'b0;
  logic reset;
  logic hold;
  logic flush;
  int   tests  = 0;
  int   errors = 0;

  fwd_hazard_tracker_if #(.REG_W(5), .NUM_SRC(3), .NUM_FWD(2)) bus ();

  fwd_hazard_tracker dut (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic valid, input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [2:0] used, input logic [4:0] rd,
                                input logic rw, input logic ld);
    bus.id_valid    = valid;
    bus.id_src      = {c, b, a};
    bus.id_src_used = used;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_is_load  = ld;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Selects are packed 2 bits per operand: A at [1:0], B at [3:2], C at [5:4]
  function automatic logic [31:0] sel_vec(input int sa, input int sb, input int sc);
    return 32'((sc << 4) | (sb << 2) | sa);
  endfunction

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b0);
    #2;
    check_output("reset_sel", 32'(bus.ex_fwd_sel), 32'd0);
    check_output("reset_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    reset = 1'b1;
    idle(2);

    // 1: back-to-back ALU dependency forwards from EX/MEM
    apply_stimulus(1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    apply_stimulus(1'b1, 5'd1, 5'd3, 5'd0, 3'b011, 5'd2, 1'b1, 1'b0);
    #1 check_output("t1_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t1_selA", 32'(bus.ex_fwd_sel), sel_vec(1, 0, 0));

    // 2: one-gap dependency uses MEM/WB; two gaps reads the regfile
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    idle(1);
    apply_stimulus(1'b1, 5'd5, 5'd1, 5'd0, 3'b011, 5'd4, 1'b1, 1'b0);
    #1 check_output("t2_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t2_selB2", 32'(bus.ex_fwd_sel), sel_vec(0, 2, 0));
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    idle(2);
    apply_stimulus(1'b1, 5'd5, 5'd1, 5'd0, 3'b011, 5'd4, 1'b1, 1'b0);
    cycle();
    check_output("t2_selB0", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));

    // 2b: two writers of X1 in flight, youngest wins; store-data operand C too
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    apply_stimulus(1'b1, 5'd4, 5'd5, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    apply_stimulus(1'b1, 5'd1, 5'd6, 5'd1, 3'b101, 5'd7, 1'b0, 1'b0);
    cycle();
    check_output("t2b_young", 32'(bus.ex_fwd_sel), sel_vec(1, 0, 1));

    // 3: load-use stalls one cycle with a bubble, then forwards from MEM/WB
    idle(3);
    apply_stimulus(1'b1, 5'd10, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 1'b1);
    #1 check_output("t3_ld_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    apply_stimulus(1'b1, 5'd9, 5'd9, 5'd0, 3'b011, 5'd2, 1'b1, 1'b0);
    #1 check_output("t3_stall1", 32'(bus.stall_id), 32'd1);
    cycle();
    check_output("t3_bubble", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));
    check_output("t3_stall2", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t3_selAB", 32'(bus.ex_fwd_sel), sel_vec(2, 2, 0));

    // 4: X31 never forwards/stalls; unused operand field never matches
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd0, 5'd0, 3'b001, 5'd31, 1'b1, 1'b1);
    cycle();
    apply_stimulus(1'b1, 5'd31, 5'd31, 5'd31, 3'b111, 5'd3, 1'b1, 1'b0);
    #1 check_output("t4_x31_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t4_x31_sel", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd0, 5'd0, 3'b001, 5'd7, 1'b1, 1'b1);
    cycle();
    apply_stimulus(1'b1, 5'd8, 5'd7, 5'd0, 3'b001, 5'd4, 1'b1, 1'b0);
    #1 check_output("t4_addi_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t4_addi_sel", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));

    // 5: flush during a load-use stall kills the load
    idle(3);
    apply_stimulus(1'b1, 5'd10, 5'd0, 5'd0, 3'b001, 5'd9, 1'b1, 1'b1);
    cycle();
    apply_stimulus(1'b1, 5'd9, 5'd3, 5'd0, 3'b011, 5'd2, 1'b1, 1'b0);
    #1 check_output("t5_pre_stall", 32'(bus.stall_id), 32'd1);
    flush = 1'b1;
    #1 check_output("t5_flush_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    flush = 1'b0;
    check_output("t5_flush_sel", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));
    #1 check_output("t5_refetch_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t5_refetch_sel", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));

    // 6: hold freezes outputs; async reset clears them and drops in-flight writers
    idle(3);
    apply_stimulus(1'b1, 5'd2, 5'd3, 5'd0, 3'b011, 5'd1, 1'b1, 1'b0);
    cycle();
    apply_stimulus(1'b1, 5'd1, 5'd3, 5'd0, 3'b011, 5'd2, 1'b1, 1'b0);
    cycle();
    check_output("t6_pre_hold", 32'(bus.ex_fwd_sel), sel_vec(1, 0, 0));
    hold = 1'b1;
    apply_stimulus(1'b1, 5'd4, 5'd2, 5'd0, 3'b011, 5'd5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_output($sformatf("t6_hold%0d", i), 32'(bus.ex_fwd_sel), sel_vec(1, 0, 0));
    end
    reset = 1'b0;
    #1 check_output("t6_async_rst", 32'(bus.ex_fwd_sel), 32'd0);
    #1 reset = 1'b1;
    hold = 1'b0;
    #1 check_output("t6_post_stall", 32'(bus.stall_id), 32'd0);
    cycle();
    check_output("t6_post_sel", 32'(bus.ex_fwd_sel), sel_vec(0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
